// File: rtl/prod_accumulator_pkg.sv
// prod_accumulator_pkg
// Shared definitions for the product accumulator block:
//   - default operand width (N) and accumulator width (ACC_W)
//   - FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
package prod_accumulator_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int ACC_W_DEFAULT = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : prod_accumulator_pkg

// File: rtl/sat_add.sv
// sat_add
// Combinational unsigned saturating adder.
// Ports:
//   a   [ACC_W]  - current accumulator value
//   b   [2*N]    - unsigned product, zero-extended to ACC_W
//   s   [ACC_W]  - a+b, clamped to all-ones on overflow
//   sat          - high when the true sum exceeded 2^ACC_W-1
module sat_add
    import prod_accumulator_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0] a,
    input  logic [2*N-1:0]   b,
    output logic [ACC_W-1:0] s,
    output logic             sat
);

    // One extra bit catches the carry out of the ACC_W-bit addition.
    logic [ACC_W:0] wide_s;

    assign wide_s = {1'b0, a} + {{(ACC_W + 1 - 2*N){1'b0}}, b};

    // Clamp to all-ones when the carry bit is set.
    always_comb begin
        sat = wide_s[ACC_W];
        if (wide_s[ACC_W]) begin
            s = {ACC_W{1'b1}};
        end else begin
            s = wide_s[ACC_W-1:0];
        end
    end

endmodule : sat_add

// File: rtl/prod_accumulator.sv
// prod_accumulator
// Accumulates a block of `len` unsigned products into a saturating
// accumulator, then presents the result with a valid/ready handshake.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clear           - synchronous abort to IDLE (acc/cnt/ovf cleared)
//   start, len      - begin a block of len products (accepted in IDLE only)
//   prod, prod_valid, prod_ready - upstream product stream
//   sum, ovf        - accumulated result and sticky saturation flag
//   out_valid, out_ready - downstream result handshake
//   busy            - high in ACCUM and DONE
module prod_accumulator
    import prod_accumulator_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic [2*N-1:0]   prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state_r;
    state_t           state_next_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_next_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_next_s;
    logic [7:0]       len_r;
    logic [7:0]       len_next_s;
    logic             ovf_r;
    logic             ovf_next_s;
    logic             prod_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [ACC_W-1:0] add_s;
    logic             add_sat_s;

    sat_add #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_r),
        .b   (prod),
        .s   (add_s),
        .sat (add_sat_s)
    );

    // Next-state and datapath update; clear overrides every state.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        cnt_next_s   = cnt_r;
        len_next_s   = len_r;
        ovf_next_s   = ovf_r;
        if (clear) begin
            state_next_s = IDLE;
            acc_next_s   = {ACC_W{1'b0}};
            cnt_next_s   = 8'd0;
            ovf_next_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_next_s = len;
                        acc_next_s = {ACC_W{1'b0}};
                        cnt_next_s = 8'd0;
                        ovf_next_s = 1'b0;
                        if (len == 8'd0) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = ACCUM;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                ACCUM: begin
                    // prod_ready is high throughout ACCUM, so prod_valid alone
                    // marks a transfer here.
                    if (prod_valid) begin
                        acc_next_s = add_s;
                        ovf_next_s = ovf_r | add_sat_s;
                        cnt_next_s = cnt_r + 8'd1;
                        if (cnt_r == (len_r - 8'd1)) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = ACCUM;
                        end
                    end else begin
                        state_next_s = ACCUM;
                    end
                end
                DONE: begin
                    // start here is deliberately ignored, even on the handoff cycle.
                    if (out_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; status outputs decoded from next state
    // so they leave the flops aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= 8'd0;
            len_r        <= 8'd0;
            ovf_r        <= 1'b0;
            prod_ready_r <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            acc_r        <= acc_next_s;
            cnt_r        <= cnt_next_s;
            len_r        <= len_next_s;
            ovf_r        <= ovf_next_s;
            prod_ready_r <= (state_next_s == ACCUM);
            out_valid_r  <= (state_next_s == DONE);
            busy_r       <= (state_next_s != IDLE);
        end
    end

    assign sum        = acc_r;
    assign ovf        = ovf_r;
    assign prod_ready = prod_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;

endmodule : prod_accumulator

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter N, default 8, SHALL set the multiplier operand width; products are 2*N bits.
REQ-002 Parameter ACC_W, default 20, SHALL set the accumulator width; ACC_W SHALL be >= 2*N.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port clear, input, 1: synchronous abort to IDLE.
REQ-006 Port start, input, 1: one-cycle request to begin a block.
REQ-007 Port len, input, 8: number of products in the block, sampled with start.
REQ-008 Port prod, input, 2*N: unsigned product from the upstream multiplier.
REQ-009 Port prod_valid, input, 1: prod is valid this cycle.
REQ-010 Port prod_ready, output, 1: block accepts prod this cycle.
REQ-011 Port sum, output, ACC_W: accumulated result.
REQ-012 Port ovf, output, 1: sticky saturation flag for the current block.
REQ-013 Port out_valid, output, 1: sum and ovf are final.
REQ-014 Port out_ready, input, 1: downstream accepts the result.
REQ-015 Port busy, output, 1: high in ACCUM and DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 IDLE: prod_ready=0, out_valid=0; start=1 SHALL latch len, clear acc, cnt and ovf, then go to ACCUM, or to DONE with sum=0 when len=0.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 ACCUM: prod_ready=1; a transfer occurs only when prod_valid and prod_ready are both high in the same cycle.
REQ-020 On each transfer, acc SHALL take acc+prod (unsigned, zero-extended to ACC_W).
REQ-021 If that addition exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and ovf SHALL set and stay set until the next start, clear or rst.
REQ-022 cnt SHALL increment on each transfer; the transfer with cnt=len-1 SHALL move the FSM to DONE.
REQ-023 Cycles with prod_valid=0 SHALL leave acc and cnt unchanged (stalls have unbounded length).
REQ-024 DONE: out_valid=1, prod_ready=0; sum and ovf SHALL be held stable until out_ready=1, then the FSM goes to IDLE.
REQ-025 sum SHALL equal acc in every state; the result is visible one cycle after the last accepted product.
REQ-026 A start in the same cycle as the DONE->IDLE handoff SHALL be ignored; start is accepted only while in IDLE.
REQ-027 clear=1 in any state SHALL force IDLE with acc=0, cnt=0 and ovf=0 on the next edge; any product offered in that cycle is dropped.
REQ-028 If rst and clear are asserted together, rst SHALL take priority; the resulting state is the same.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, sum=0, ovf=0, out_valid=0, prod_ready=0, busy=0, cnt=0 and latched len=0.
REQ-030 A reset mid-block SHALL discard the partial sum without asserting out_valid.

Structure
REQ-031 A shared package SHALL hold the defaults for N and ACC_W and the state encoding typedef (IDLE=0, ACCUM=1, DONE=2).
REQ-032 Saturating addition SHALL live in one combinational sub-module, sat_add, with inputs a[ACC_W] and b[2*N] and outputs s[ACC_W] and sat.
REQ-033 The FSM, counter and registers SHALL be in prod_accumulator; there are no other sub-modules.

Verification
REQ-034 The bench SHALL cover: start with len=3, prods 0x0010, 0x0020, 0x0030 with no stalls -> out_valid one cycle after the third transfer, sum=0x00060, ovf=0.
REQ-035 The bench SHALL cover: len=2, prods 0x00FF then 0x0001, with 5 idle cycles between them -> sum=0x00100; prod_ready stays high and acc holds during the gap.
REQ-036 The bench SHALL cover: len=17, every prod=0xFE01 (255*255) -> sum=0xFFFFF, ovf=1 set on the 17th transfer.
REQ-037 The bench SHALL cover: len=0 start -> DONE next cycle, sum=0, ovf=0, with no prod_ready assertion.
REQ-038 The bench SHALL cover: out_ready held low for 4 cycles in DONE -> sum and out_valid stable; start pulses ignored; IDLE after out_ready=1.
REQ-039 The bench SHALL cover: clear, then separately rst, after 2 of 4 transfers -> next cycle IDLE, sum=0, busy=0, no out_valid; a fresh len=1 block with prod 0x0005 gives sum=0x00005.
